pico_bus_fifo_port: RTL

PICO_BUS_FIFO_PORT -- requirements
Module: pico_bus_fifo_port

---
 rtl/pico_fifo_port_pkg.sv | 31 +++
 rtl/pico_bus_fifo_port_fifo.sv | 57 +++++
 rtl/pico_bus_fifo_port.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pico_fifo_port_pkg.sv
// Shared register map, STATUS/CTRL bit positions and address decode for the PicoBus FIFO port.
package pico_fifo_port_pkg;

    localparam logic [5:0] OFF_DATA   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h10;
    localparam logic [5:0] OFF_CTRL   = 6'h20;

    localparam int STAT_TX_LVL_LSB = 0;
    localparam int STAT_RX_LVL_LSB = 16;
    localparam int STAT_TX_OVF_BIT = 32;
    localparam int STAT_RX_UNF_BIT = 33;

    localparam int CTRL_CLR_BIT   = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    typedef enum logic [1:0] {
        REG_DATA,
        REG_STATUS,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

    // Offset bits [5:4] select the 16-byte register slot inside the 64-byte window.
    function automatic reg_sel_e decode_reg(input logic [1:0] slot);
        if (slot == OFF_DATA[5:4])        return REG_DATA;
        else if (slot == OFF_STATUS[5:4]) return REG_STATUS;
        else if (slot == OFF_CTRL[5:4])   return REG_CTRL;
        else                              return REG_NONE;
    endfunction

endpackage

// File: rtl/pico_bus_fifo_port_fifo.sv
// pico_sync_fifo: single-clock FIFO with level counter and synchronous flush.
// Push into a full FIFO and pop from an empty one are ignored; flush wins over both.
module pico_sync_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [W-1:0]             head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pico_bus_fifo_port.sv
// PicoBus slave bridging a 3-register window to TX/RX streams through two FIFOs.
// Sticky error flags are built only with PICO_FIFO_PORT_ERR_FLAGS_EN defined.
module pico_bus_fifo_port
    import pico_fifo_port_pkg::*;
#(
    parameter int          W         = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          DEPTH     = 16
) (
    input  logic          PicoClk,
    input  logic          PicoRst,
    input  logic          PicoWr,
    input  logic          PicoRd,
    input  logic [31:0]   PicoAddr,
    input  logic [W-1:0]  PicoDataIn,
    output logic [W-1:0]  PicoDataOut,
    output logic          tx_valid,
    input  logic          tx_rdy,
    output logic [W-1:0]  tx_data,
    input  logic          rx_valid,
    output logic          rx_rdy,
    input  logic [W-1:0]  rx_data
);

    localparam int LW = $clog2(DEPTH) + 1;

    reg_sel_e      sel;
    logic          wr_data_hit;
    logic          wr_ctrl_hit;
    logic          rd_data_hit;
    logic          flush;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic [W-1:0]  rx_head;
    logic          rx_en;
    logic          tx_ovf;
    logic          rx_unf;
    logic [63:0]   status_word;
    logic [W-1:0]  rd_next;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^PicoAddr[3:0];

    assign sel = (PicoAddr[31:6] == BASE_ADDR[31:6]) ? decode_reg(PicoAddr[5:4]) : REG_NONE;
    assign wr_data_hit = PicoWr && (sel == REG_DATA);
    assign wr_ctrl_hit = PicoWr && (sel == REG_CTRL);
    assign rd_data_hit = PicoRd && (sel == REG_DATA);
    assign flush       = wr_ctrl_hit && PicoDataIn[CTRL_FLUSH_BIT];

    assign tx_valid = !tx_empty;
    // rx_en keeps rx_rdy low through reset and until the first edge afterwards.
    assign rx_rdy   = rx_en && !rx_full;

    pico_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (PicoClk),
        .rst   (PicoRst),
        .push  (wr_data_hit),
        .din   (PicoDataIn),
        .pop   (tx_valid && tx_rdy),
        .flush (flush),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level),
        .head  (tx_data)
    );

    pico_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (PicoClk),
        .rst   (PicoRst),
        .push  (rx_valid && rx_rdy),
        .din   (rx_data),
        .pop   (rd_data_hit),
        .flush (flush),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level),
        .head  (rx_head)
    );

    always_ff @(posedge PicoClk or posedge PicoRst) begin
        if (PicoRst) rx_en <= 1'b0;
        else         rx_en <= 1'b1;
    end

`ifdef PICO_FIFO_PORT_ERR_FLAGS_EN
    logic clr_flags;
    assign clr_flags = wr_ctrl_hit && PicoDataIn[CTRL_CLR_BIT];

    // A new error in the clearing cycle survives the clear.
    always_ff @(posedge PicoClk or posedge PicoRst) begin
        if (PicoRst) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            if (clr_flags) begin
                tx_ovf <= 1'b0;
                rx_unf <= 1'b0;
            end
            if (wr_data_hit && tx_full)  tx_ovf <= 1'b1;
            if (rd_data_hit && rx_empty) rx_unf <= 1'b1;
        end
    end
`else
    assign tx_ovf = 1'b0;
    assign rx_unf = 1'b0;
`endif

    always_comb begin
        status_word = '0;
        status_word[STAT_TX_LVL_LSB +: 16] = 16'(tx_level);
        status_word[STAT_RX_LVL_LSB +: 16] = 16'(rx_level);
        status_word[STAT_TX_OVF_BIT]       = tx_ovf;
        status_word[STAT_RX_UNF_BIT]       = rx_unf;
    end

    always_comb begin
        rd_next = '0;
        if (PicoRd) begin
            case (sel)
                REG_DATA:   if (!rx_empty) rd_next = rx_head;
                REG_STATUS: rd_next = W'(status_word);
                default:    rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge PicoClk or posedge PicoRst) begin
        if (PicoRst) PicoDataOut <= '0;
        else         PicoDataOut <= rd_next;
    end

endmodule
